// File: rtl/conv_uart_pkg.sv
// Shared definitions for the convolution-to-UART pixel packetizer.
//   PIX_W       : width of one convolution result pixel
//   SYNC0_BYTE  : first frame sync byte
//   SYNC1_BYTE  : second frame sync byte
//   state_e     : packetizer FSM states
// Optional feature macro: PACKETIZER_CHECKSUM_EN adds the StCsum state.
package conv_uart_pkg;

  localparam int unsigned PIX_W      = 16;
  localparam logic [7:0]  SYNC0_BYTE = 8'hA5;
  localparam logic [7:0]  SYNC1_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    StIdle,
    StSync0,
    StSync1,
    StLenHi,
    StLenLo,
    StPixHi,
    StPixLo
`ifdef PACKETIZER_CHECKSUM_EN
    , StCsum
`endif
  } state_e;

endpackage

// File: rtl/pixel_packetizer_if.sv
// Handshake bundle between the pixel source, the packetizer and the UART transmitter.
//   pix_data/pix_valid/pix_ready : pixel stream into the packetizer
//   tx_data/tx_valid/tx_ready    : byte stream toward the UART transmitter
//   frame_done                   : one-cycle pulse after the last byte of a frame
// modport slave  : packetizer side
// modport master : environment side (pixel source + transmitter)
interface pixel_packetizer_if;
  import conv_uart_pkg::*;

  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             frame_done;

  modport slave (
    input  pix_data,
    input  pix_valid,
    output pix_ready,
    output tx_data,
    output tx_valid,
    input  tx_ready,
    output frame_done
  );

  modport master (
    output pix_data,
    output pix_valid,
    input  pix_ready,
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    input  frame_done
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push_i     : write wr_data_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   rd_data_o  : current head, valid whenever empty_o is low
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy tracking alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/pixel_packetizer.sv
// Packs 16-bit convolution pixels into framed bytes for a UART transmitter.
// Frame: A5 5A LEN_HI LEN_LO {PIX_HI PIX_LO} x FRAME_LEN [CSUM]
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pixel_packetizer_if.slave (pixel in, byte out, frame_done pulse)
// Parameters: FRAME_LEN pixels per frame (1..65535), FIFO_DEPTH pixel buffer entries.
// Macro PACKETIZER_CHECKSUM_EN appends an XOR checksum over LEN_HI, LEN_LO and
// all pixel bytes; without it the frame ends after the last PIX_LO byte.
module pixel_packetizer
  import conv_uart_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = 64,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input logic               clk,
  input logic               rst,
  pixel_packetizer_if.slave bus
);

  localparam logic [15:0] FrameLenW = 16'(FRAME_LEN);
  localparam logic [15:0] LastIdx   = 16'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [15:0]      pix_cnt_q, pix_cnt_d;
  logic             frame_done_q, frame_done_d;
`ifdef PACKETIZER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic             pix_ready;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PIX_W-1:0] fifo_head;
  logic             tx_valid, tx_fire;
  logic [7:0]       tx_data;

  // Fullness is taken before any same-cycle pop, so a full FIFO never accepts.
  assign pix_ready = ~rst & ~fifo_full;
  assign fifo_push = bus.pix_valid & pix_ready;

  sync_fifo #(
    .WIDTH(PIX_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (fifo_push),
    .wr_data_i(bus.pix_data),
    .pop_i    (fifo_pop),
    .rd_data_o(fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    tx_valid     = 1'b0;
    tx_data      = '0;
    tx_fire      = 1'b0;
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    fifo_pop     = 1'b0;
    frame_done_d = 1'b0;
`ifdef PACKETIZER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    // Byte presented in each state; it depends only on state and FIFO head,
    // neither of which changes until the byte is taken.
    case (state_q)
      StSync0: begin
        tx_valid = 1'b1;
        tx_data  = SYNC0_BYTE;
      end
      StSync1: begin
        tx_valid = 1'b1;
        tx_data  = SYNC1_BYTE;
      end
      StLenHi: begin
        tx_valid = 1'b1;
        tx_data  = FrameLenW[15:8];
      end
      StLenLo: begin
        tx_valid = 1'b1;
        tx_data  = FrameLenW[7:0];
      end
      // Wait here with tx_valid low on an empty FIFO instead of sending filler.
      StPixHi: begin
        tx_valid = ~fifo_empty;
        tx_data  = fifo_head[15:8];
      end
      StPixLo: begin
        tx_valid = ~fifo_empty;
        tx_data  = fifo_head[7:0];
      end
`ifdef PACKETIZER_CHECKSUM_EN
      StCsum: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
      end
`endif
      default: begin
        tx_valid = 1'b0;
        tx_data  = '0;
      end
    endcase

    tx_fire = tx_valid & bus.tx_ready;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d   = StSync0;
          pix_cnt_d = '0;
`ifdef PACKETIZER_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      StSync0: if (tx_fire) state_d = StSync1;
      StSync1: if (tx_fire) state_d = StLenHi;
      StLenHi: if (tx_fire) state_d = StLenLo;
      StLenLo: if (tx_fire) state_d = StPixHi;
      StPixHi: if (tx_fire) state_d = StPixLo;
      StPixLo: begin
        if (tx_fire) begin
          fifo_pop  = 1'b1;
          pix_cnt_d = pix_cnt_q + 16'd1;
          if (pix_cnt_q == LastIdx) begin
`ifdef PACKETIZER_CHECKSUM_EN
            state_d      = StCsum;
`else
            state_d      = StIdle;
            frame_done_d = 1'b1;
`endif
          end else begin
            state_d = StPixHi;
          end
        end
      end
`ifdef PACKETIZER_CHECKSUM_EN
      StCsum: begin
        if (tx_fire) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

`ifdef PACKETIZER_CHECKSUM_EN
    // Sync bytes and the checksum itself are excluded from the XOR.
    if (tx_fire && (state_q inside {StLenHi, StLenLo, StPixHi, StPixLo})) begin
      csum_d = csum_q ^ tx_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef PACKETIZER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
`ifdef PACKETIZER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.tx_valid   = tx_valid;
  assign bus.tx_data    = tx_data;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_packetizer.sv
// Self-checking bench for pixel_packetizer (FRAME_LEN=2, FIFO_DEPTH=4).
// A reference model turns every accepted pixel into the bytes the frame format
// dictates; a negedge monitor compares each transferred byte and frame_done pulse.
module tb_pixel_packetizer;
  import conv_uart_pkg::*;

  localparam int unsigned FrameLen  = 2;
  localparam int unsigned FifoDepth = 4;
`ifdef PACKETIZER_CHECKSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_packetizer_if bus ();

  pixel_packetizer #(
    .FRAME_LEN (FrameLen),
    .FIFO_DEPTH(FifoDepth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  exp_q[$];
  bit          last_q[$];
  logic [7:0]  seen_q[$];
  int unsigned pix_idx   = 0;
  logic [7:0]  csum_m    = '0;
  bit          done_pend = 1'b0;
  int          done_cnt  = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data  = '0;

  task automatic model_push(input logic [15:0] p);
    logic [7:0] hi, lo, lh, ll;
    bit         is_last;
    hi = 8'(p >> 8);
    lo = 8'(p);
    lh = 8'(FrameLen >> 8);
    ll = 8'(FrameLen);
    if (pix_idx % FrameLen == 0) begin
      exp_q.push_back(8'hA5); last_q.push_back(1'b0);
      exp_q.push_back(8'h5A); last_q.push_back(1'b0);
      exp_q.push_back(lh);    last_q.push_back(1'b0);
      exp_q.push_back(ll);    last_q.push_back(1'b0);
      csum_m = lh ^ ll;
    end
    is_last = (pix_idx % FrameLen == FrameLen - 1);
    exp_q.push_back(hi); last_q.push_back(1'b0);
    exp_q.push_back(lo); last_q.push_back(is_last && !CsumEn);
    csum_m = csum_m ^ hi ^ lo;
    if (is_last && CsumEn) begin
      exp_q.push_back(csum_m); last_q.push_back(1'b1);
    end
    pix_idx++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_q.delete();
      seen_q.delete();
      pix_idx    = 0;
      done_pend  = 1'b0;
      done_cnt   = 0;
      prev_stall = 1'b0;
    end else begin
      if (done_pend || bus.frame_done) check_eq("frame_done", bus.frame_done, done_pend);
      if (bus.frame_done) done_cnt++;
      done_pend = 1'b0;
      if (prev_stall) check_eq("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, prev_data});
      if (bus.pix_valid && bus.pix_ready) model_push(bus.pix_data);
      if (bus.tx_valid && bus.tx_ready) begin
        seen_q.push_back(bus.tx_data);
        if (exp_q.size() == 0) begin
          check_eq("tx_extra_byte", bus.tx_data, 32'hFFFF_FFFF);
        end else begin
          check_eq("tx_byte", bus.tx_data, exp_q.pop_front());
          done_pend = last_q.pop_front();
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  // All directed steps run in the phase just after a rising edge.
  task automatic do_reset();
    rst           = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.tx_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_tx_valid", bus.tx_valid, 0);
    check_eq("rst_tx_data", bus.tx_data, 0);
    check_eq("rst_pix_ready", bus.pix_ready, 0);
    check_eq("rst_frame_done", bus.frame_done, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", bus.pix_ready, 1);
  endtask

  task automatic push_pix(input logic [15:0] d);
    int w = 0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    while (!bus.pix_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 200) check_eq("push_timeout", 0, 1);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic step_byte();
    int w = 0;
    while (!bus.tx_valid && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 100) check_eq("step_timeout", 0, 1);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w = 0;
    while (exp_q.size() != 0 && w < 1000) begin
      @(posedge clk); #1; w++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq(tag, exp_q.size(), 0);
  endtask

  logic [7:0]  golden[9];
  logic [15:0] pix6[6];

  initial begin
    int glen, acc, bad, w;
    bit rdy;
    golden = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    glen   = CsumEn ? 9 : 8;

    // Known two-pixel frame plus first-byte latency
    do_reset();
    bus.tx_ready  = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_data  = 16'h1234;
    @(posedge clk); #1;
    bus.pix_data = 16'hABCD;
    check_eq("lat_n1_valid", bus.tx_valid, 0);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    check_eq("lat_n2_valid", bus.tx_valid, 1);
    check_eq("lat_n2_data", bus.tx_data, 8'hA5);
    repeat (20) @(posedge clk);
    #1;
    check_eq("frame_len_bytes", seen_q.size(), glen);
    for (int i = 0; i < glen; i++) check_eq("golden_byte", seen_q[i], golden[i]);
    check_eq("frame_done_count", done_cnt, 1);

    // Back-pressure held at LEN_LO
    do_reset();
    push_pix(16'h1234);
    push_pix(16'hABCD);
    repeat (3) step_byte();
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (!(bus.tx_valid && bus.tx_data == 8'h02)) bad++;
    end
    check_eq("len_lo_hold", bad, 0);
    bus.tx_ready = 1'b1;
    wait_drain("len_lo_drain");

    // FIFO fill to full, then release
    do_reset();
    for (int i = 0; i < 6; i++) pix6[i] = 16'($urandom);
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix6[acc];
      rdy = bus.pix_ready;
      @(posedge clk); #1;
      if (rdy) acc++;
    end
    check_eq("full_writes", acc, FifoDepth);
    check_eq("full_pix_ready", bus.pix_ready, 0);
    bus.tx_ready = 1'b1;
    w = 0;
    while (acc < 6 && w < 200) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix6[acc];
      rdy = bus.pix_ready;
      @(posedge clk); #1;
      if (rdy) acc++;
      w++;
    end
    bus.pix_valid = 1'b0;
    check_eq("full_all_accepted", acc, 6);
    wait_drain("full_drain");
    check_eq("full_frames", done_cnt, 3);

    // Underrun wait in PIX_HI
    do_reset();
    bus.tx_ready = 1'b1;
    push_pix(16'($urandom));
    repeat (20) @(posedge clk);
    #1;
    check_eq("underrun_bytes", seen_q.size(), 6);
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.tx_valid) bad++;
    end
    check_eq("underrun_valid_low", bad, 0);
    push_pix(16'($urandom));
    wait_drain("underrun_drain");
    check_eq("underrun_frames", done_cnt, 1);

    // Reset in mid-frame after 0x12 went out
    do_reset();
    push_pix(16'h1234);
    push_pix(16'hABCD);
    repeat (5) step_byte();
    check_eq("mid_bytes", seen_q.size(), 5);
    check_eq("mid_last_byte", seen_q[4], 8'h12);
    do_reset();
    push_pix(16'h5678);
    step_byte();
    check_eq("restart_a5", seen_q[0], 8'hA5);
    bus.tx_ready = 1'b1;
    push_pix(16'h9ABC);
    wait_drain("restart_drain");
    check_eq("restart_frames", done_cnt, 1);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bus.pix_valid = ($urandom_range(0, 3) == 0);
      bus.pix_data  = 16'($urandom);
      bus.tx_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
    bus.tx_ready  = 1'b1;
    if (pix_idx % FrameLen != 0) push_pix(16'($urandom));
    wait_drain("random_drain");
    check_eq("random_idle", bus.tx_valid, 0);
    check_eq("random_frames", done_cnt, pix_idx / FrameLen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_packetizer.md
PIXEL_PACKETIZER -- requirements
Module: pixel_packetizer

Interface
REQ-001 Parameter FRAME_LEN, default 64, pixels per frame (1..65535).
REQ-002 Parameter FIFO_DEPTH, default 32, pixel FIFO entries (power of two, >=2).
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port pix_data  input  16  convolution result pixel.
REQ-006 Port pix_valid  input  1  pixel offered.
REQ-007 Port pix_ready  output  1  FIFO not full.
REQ-008 Port tx_data  output  8  byte toward UART transmitter.
REQ-009 Port tx_valid  output  1  tx_data valid.
REQ-010 Port tx_ready  input  1  transmitter idle, byte accepted.
REQ-011 Port frame_done  output  1  one-cycle pulse after last byte of a frame is accepted.

Function
REQ-012 Pixel write SHALL occur exactly when pix_valid && pix_ready; byte transfer SHALL occur exactly when tx_valid && tx_ready.
REQ-013 Frame byte order SHALL be: 0xA5, 0x5A, FRAME_LEN[15:8], FRAME_LEN[7:0], then per pixel MSB then LSB, then checksum (only if CHECKSUM_EN).
REQ-014 FSM states SHALL be IDLE, SYNC0, SYNC1, LEN_HI, LEN_LO, PIX_HI, PIX_LO, CSUM.
REQ-015 IDLE->SYNC0 when FIFO non-empty; each other state SHALL advance only on a byte transfer.
REQ-016 PIX_LO->PIX_HI while pixel count < FRAME_LEN; otherwise PIX_LO->CSUM (macro on) or ->IDLE (macro off).
REQ-017 CSUM->IDLE on transfer; frame_done SHALL pulse the cycle after the final transfer.
REQ-018 FIFO pop SHALL occur on the PIX_LO transfer; PIX_HI/PIX_LO SHALL read FIFO head without a read-latency bubble.
REQ-019 In PIX_HI with empty FIFO, tx_valid SHALL be 0 and the FSM SHALL wait (no underrun, no filler byte).
REQ-020 tx_data SHALL remain stable while tx_valid && !tx_ready; tx_valid SHALL NOT drop without a transfer.
REQ-021 Latency: pixel written at cycle N into empty FIFO in IDLE -> tx_valid=1 with 0xA5 at cycle N+2.
REQ-022 FIFO full: pix_ready=0; simultaneous push and pop on a full FIFO SHALL NOT be permitted (pix_ready evaluated pre-pop).
REQ-023 Simultaneous push and pop on non-full, non-empty FIFO SHALL keep occupancy constant.
REQ-024 Pixel counter width SHALL be 16 bits; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-025 During rst: state=IDLE, FIFO empty, counters 0, checksum 0, tx_valid=0, tx_data=0, pix_ready=0, frame_done=0.
REQ-026 pix_ready SHALL become 1 the first cycle after rst deasserts.
REQ-027 rst mid-frame SHALL discard the partial frame and FIFO contents; the next frame SHALL restart at 0xA5.

Configuration
REQ-028 Macro PACKETIZER_CHECKSUM_EN defined: CSUM state present; checksum = XOR of LEN_HI, LEN_LO and all pixel bytes, cleared on entering SYNC0.
REQ-029 Macro undefined: CSUM state and checksum register absent; frame ends after last PIX_LO byte.

Structure
REQ-030 Package conv_uart_pkg SHALL hold the state enum, SYNC0_BYTE=0xA5, SYNC1_BYTE=0x5A and PIX_W=16.
REQ-031 Sub-module sync_fifo (parameters WIDTH, DEPTH; first-word-fall-through) SHALL implement the pixel buffer.

Verification
REQ-032 FRAME_LEN=2, pixels 0x1234, 0xABCD, tx_ready=1, macro on -> bytes A5 5A 00 02 12 34 AB CD 42, frame_done once.
REQ-033 Same stimulus, macro off -> bytes A5 5A 00 02 12 34 AB CD, no CSUM byte.
REQ-034 tx_ready held 0 for 100 cycles at LEN_LO -> tx_data=0x02 and tx_valid=1 stable throughout.
REQ-035 FIFO_DEPTH=4, 6 pixels offered with tx_ready=0 -> pix_ready=0 after 4 writes, no data loss after release.
REQ-036 Second pixel withheld 50 cycles -> tx_valid=0 in PIX_HI, frame resumes with correct bytes.
REQ-037 rst asserted after 0x12 transferred -> outputs at reset values; next frame begins with 0xA5.
